// File: rtl/aurora_params.sv
// Shared types and defaults for the Aurora RX guard blocks.
package aurora_params;

  // Per-channel guard state: between frames, forwarding a frame, discarding a frame.
  typedef enum logic [1:0] {
    WAIT = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } guard_state_e;

  // Default width of the per-channel drop counter.
  localparam int RX_GUARD_CNT_W = 16;

endpackage : aurora_params

// File: rtl/aurora_rx_guard_ch.sv
// One channel of the frame-aware RX guard: frame state machine, watermark
// hysteresis flag, registered output stage and saturating drop counter.
module aurora_rx_guard_ch
  import aurora_params::*;
#(
  parameter int DATA_W = 128,
  parameter int KEEP_W = DATA_W / 8,
  parameter int CNT_W  = RX_GUARD_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              channel_up_i,
  input  logic              fifo_ready_i,
  input  logic              fifo_below_lwm_i,
  input  logic              fifo_above_hwm_i,
  input  logic              stat_clr_i,
  input  logic [DATA_W-1:0] rx_tdata_i,
  input  logic [KEEP_W-1:0] rx_tkeep_i,
  input  logic              rx_tvalid_i,
  input  logic              rx_tlast_i,
  output logic [DATA_W-1:0] rx_tdata_o,
  output logic [KEEP_W-1:0] rx_tkeep_o,
  output logic              rx_tvalid_o,
  output logic              rx_tlast_o,
  output logic              rx_terr_o,
  output logic              loss_data_o,
  output logic              loss_frame_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  guard_state_e      state_q, state_d;
  logic              blocked_q, blocked_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic [KEEP_W-1:0] tkeep_q, tkeep_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic              terr_q, terr_d;
  logic              loss_data_q, loss_data_d;
  logic              loss_frame_q, loss_frame_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ok_s;
  logic              inc_s;

  assign ok_s = channel_up_i & fifo_ready_i;

  // Watermark hysteresis: HWM sets (and wins over LWM), LWM clears, else hold.
  always_comb begin
    blocked_d = blocked_q;
    if (fifo_above_hwm_i) begin
      blocked_d = 1'b1;
    end else if (fifo_below_lwm_i) begin
      blocked_d = 1'b0;
    end else begin
      blocked_d = blocked_q;
    end
  end

  // Frame state machine and next output beat; payload holds when idle.
  always_comb begin
    state_d      = state_q;
    tdata_d      = tdata_q;
    tkeep_d      = tkeep_q;
    tvalid_d     = 1'b0;
    tlast_d      = 1'b0;
    terr_d       = 1'b0;
    loss_data_d  = 1'b0;
    loss_frame_d = 1'b0;
    inc_s        = 1'b0;
    case (state_q)
      WAIT: begin
        if (!rx_tvalid_i) begin
          state_d = WAIT;
        end else if (!channel_up_i) begin
          // Link down between frames: nothing worth accounting.
          state_d = WAIT;
        end else if (ok_s && !blocked_q) begin
          tdata_d  = rx_tdata_i;
          tkeep_d  = rx_tkeep_i;
          tvalid_d = 1'b1;
          tlast_d  = rx_tlast_i;
          state_d  = rx_tlast_i ? WAIT : PASS;
        end else begin
          loss_frame_d = 1'b1;
          inc_s        = 1'b1;
          state_d      = rx_tlast_i ? WAIT : DROP;
        end
      end
      PASS: begin
        if (ok_s) begin
          // Watermarks are ignored mid-frame; only link/FIFO loss truncates.
          if (rx_tvalid_i) begin
            tdata_d  = rx_tdata_i;
            tkeep_d  = rx_tkeep_i;
            tvalid_d = 1'b1;
            tlast_d  = rx_tlast_i;
            state_d  = rx_tlast_i ? WAIT : PASS;
          end else begin
            state_d = PASS;
          end
        end else begin
          // Close the partial frame with an empty, error-marked last beat.
          tdata_d     = '0;
          tkeep_d     = '0;
          tvalid_d    = 1'b1;
          tlast_d     = 1'b1;
          terr_d      = 1'b1;
          loss_data_d = 1'b1;
          inc_s       = 1'b1;
          state_d     = channel_up_i ? DROP : WAIT;
        end
      end
      DROP: begin
        if (!channel_up_i || (rx_tvalid_i && rx_tlast_i)) begin
          state_d = WAIT;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = WAIT;
      end
    endcase
  end

  // Drop counter: clear has priority but a coincident event still counts once.
  always_comb begin
    cnt_d = cnt_q;
    if (stat_clr_i) begin
      cnt_d = inc_s ? CNT_ONE : '0;
    end else if (inc_s && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, flag, output and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= WAIT;
      blocked_q    <= 1'b0;
      tdata_q      <= '0;
      tkeep_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      terr_q       <= 1'b0;
      loss_data_q  <= 1'b0;
      loss_frame_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      blocked_q    <= blocked_d;
      tdata_q      <= tdata_d;
      tkeep_q      <= tkeep_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      terr_q       <= terr_d;
      loss_data_q  <= loss_data_d;
      loss_frame_q <= loss_frame_d;
      cnt_q        <= cnt_d;
    end
  end

  assign rx_tdata_o   = tdata_q;
  assign rx_tkeep_o   = tkeep_q;
  assign rx_tvalid_o  = tvalid_q;
  assign rx_tlast_o   = tlast_q;
  assign rx_terr_o    = terr_q;
  assign loss_data_o  = loss_data_q;
  assign loss_frame_o = loss_frame_q;
  assign drop_cnt_o   = cnt_q;

endmodule : aurora_rx_guard_ch

// File: rtl/aurora_rx_guard_mc.sv
// Multi-channel RX guard: one independent guard per Aurora channel, with a
// shared statistics clear.
module aurora_rx_guard_mc
  import aurora_params::*;
#(
  parameter int CH_CNT = 1,
  parameter int DATA_W = 128,
  parameter int KEEP_W = DATA_W / 8,
  parameter int CNT_W  = RX_GUARD_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CH_CNT-1:0]        channel_up,
  input  logic [CH_CNT-1:0]        fifo_ready,
  input  logic [CH_CNT-1:0]        fifo_below_lwm,
  input  logic [CH_CNT-1:0]        fifo_above_hwm,
  input  logic                     stat_clr,
  input  logic [CH_CNT*DATA_W-1:0] i_rx_tdata,
  input  logic [CH_CNT*KEEP_W-1:0] i_rx_tkeep,
  input  logic [CH_CNT-1:0]        i_rx_tvalid,
  input  logic [CH_CNT-1:0]        i_rx_tlast,
  output logic [CH_CNT*DATA_W-1:0] o_rx_tdata,
  output logic [CH_CNT*KEEP_W-1:0] o_rx_tkeep,
  output logic [CH_CNT-1:0]        o_rx_tvalid,
  output logic [CH_CNT-1:0]        o_rx_tlast,
  output logic [CH_CNT-1:0]        o_rx_terr,
  output logic [CH_CNT-1:0]        loss_data,
  output logic [CH_CNT-1:0]        loss_frame,
  output logic [CH_CNT*CNT_W-1:0]  stat_drop_cnt
);

  for (genvar g = 0; g < CH_CNT; g++) begin : g_ch
    aurora_rx_guard_ch #(
      .DATA_W (DATA_W),
      .KEEP_W (KEEP_W),
      .CNT_W  (CNT_W)
    ) u_ch (
      .clk              (clk),
      .rst              (rst),
      .channel_up_i     (channel_up[g]),
      .fifo_ready_i     (fifo_ready[g]),
      .fifo_below_lwm_i (fifo_below_lwm[g]),
      .fifo_above_hwm_i (fifo_above_hwm[g]),
      .stat_clr_i       (stat_clr),
      .rx_tdata_i       (i_rx_tdata[g*DATA_W +: DATA_W]),
      .rx_tkeep_i       (i_rx_tkeep[g*KEEP_W +: KEEP_W]),
      .rx_tvalid_i      (i_rx_tvalid[g]),
      .rx_tlast_i       (i_rx_tlast[g]),
      .rx_tdata_o       (o_rx_tdata[g*DATA_W +: DATA_W]),
      .rx_tkeep_o       (o_rx_tkeep[g*KEEP_W +: KEEP_W]),
      .rx_tvalid_o      (o_rx_tvalid[g]),
      .rx_tlast_o       (o_rx_tlast[g]),
      .rx_terr_o        (o_rx_terr[g]),
      .loss_data_o      (loss_data[g]),
      .loss_frame_o     (loss_frame[g]),
      .drop_cnt_o       (stat_drop_cnt[g*CNT_W +: CNT_W])
    );
  end : g_ch

endmodule : aurora_rx_guard_mc

// File: tb/tb_aurora_rx_guard_mc.sv
// Directed bench for aurora_rx_guard_mc with two channels and a 4-bit counter.
module tb_aurora_rx_guard_mc;

  localparam int CH_CNT = 2;
  localparam int DATA_W = 128;
  localparam int KEEP_W = 16;
  localparam int CNT_W  = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [CH_CNT-1:0]        channel_up, fifo_ready, fifo_below_lwm, fifo_above_hwm;
  logic                     stat_clr;
  logic [CH_CNT*DATA_W-1:0] i_rx_tdata;
  logic [CH_CNT*KEEP_W-1:0] i_rx_tkeep;
  logic [CH_CNT-1:0]        i_rx_tvalid, i_rx_tlast;
  logic [CH_CNT*DATA_W-1:0] o_rx_tdata;
  logic [CH_CNT*KEEP_W-1:0] o_rx_tkeep;
  logic [CH_CNT-1:0]        o_rx_tvalid, o_rx_tlast, o_rx_terr, loss_data, loss_frame;
  logic [CH_CNT*CNT_W-1:0]  stat_drop_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  aurora_rx_guard_mc #(
    .CH_CNT (CH_CNT),
    .DATA_W (DATA_W),
    .KEEP_W (KEEP_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .channel_up     (channel_up),
    .fifo_ready     (fifo_ready),
    .fifo_below_lwm (fifo_below_lwm),
    .fifo_above_hwm (fifo_above_hwm),
    .stat_clr       (stat_clr),
    .i_rx_tdata     (i_rx_tdata),
    .i_rx_tkeep     (i_rx_tkeep),
    .i_rx_tvalid    (i_rx_tvalid),
    .i_rx_tlast     (i_rx_tlast),
    .o_rx_tdata     (o_rx_tdata),
    .o_rx_tkeep     (o_rx_tkeep),
    .o_rx_tvalid    (o_rx_tvalid),
    .o_rx_tlast     (o_rx_tlast),
    .o_rx_terr      (o_rx_terr),
    .loss_data      (loss_data),
    .loss_frame     (loss_frame),
    .stat_drop_cnt  (stat_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic l, input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k);
    i_rx_tvalid[0]          = v;
    i_rx_tlast[0]           = l;
    i_rx_tdata[DATA_W-1:0]  = d;
    i_rx_tkeep[KEEP_W-1:0]  = k;
  endtask

  task automatic drive1(input logic v, input logic l, input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k);
    i_rx_tvalid[1]                 = v;
    i_rx_tlast[1]                  = l;
    i_rx_tdata[2*DATA_W-1:DATA_W]  = d;
    i_rx_tkeep[2*KEEP_W-1:KEEP_W]  = k;
  endtask

  // Check the full ch0 output beat against an expected beat.
  task automatic check_beat0(input string tag, input logic v, input logic l, input logic e,
                             input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k);
    check_val({tag, "_valid"}, DATA_W'(o_rx_tvalid[0]), DATA_W'(v));
    check_val({tag, "_last"},  DATA_W'(o_rx_tlast[0]),  DATA_W'(l));
    check_val({tag, "_err"},   DATA_W'(o_rx_terr[0]),   DATA_W'(e));
    check_val({tag, "_data"},  o_rx_tdata[DATA_W-1:0],  d);
    check_val({tag, "_keep"},  DATA_W'(o_rx_tkeep[KEEP_W-1:0]), DATA_W'(k));
  endtask

  initial begin
    rst = 1'b1;
    channel_up = 2'b11; fifo_ready = 2'b11; fifo_below_lwm = 2'b00; fifo_above_hwm = 2'b00;
    stat_clr = 1'b0;
    i_rx_tdata = '0; i_rx_tkeep = '0; i_rx_tvalid = 2'b00; i_rx_tlast = 2'b00;
    #23;
    check_val("rst_valid", DATA_W'(o_rx_tvalid), '0);
    check_val("rst_cnt", DATA_W'(stat_drop_cnt), '0);
    check_val("rst_loss", DATA_W'({loss_data, loss_frame}), '0);
    rst = 1'b0;
    tick();

    // 3-beat frame forwarded unchanged with 1-cycle latency.
    drive0(1'b1, 1'b0, 128'hA1, 16'hFFFF); tick();
    check_beat0("t1_b1", 1'b1, 1'b0, 1'b0, 128'hA1, 16'hFFFF);
    drive0(1'b1, 1'b0, 128'hA2, 16'hFFFF); tick();
    check_beat0("t1_b2", 1'b1, 1'b0, 1'b0, 128'hA2, 16'hFFFF);
    drive0(1'b1, 1'b1, 128'hA3, 16'h00FF); tick();
    check_beat0("t1_b3", 1'b1, 1'b1, 1'b0, 128'hA3, 16'h00FF);
    check_val("t1_pulses", DATA_W'({loss_data[0], loss_frame[0]}), '0);
    drive0(1'b0, 1'b0, 128'h0, 16'h0); tick();
    check_val("t1_idle", DATA_W'(o_rx_tvalid[0]), '0);
    check_val("t1_cnt", DATA_W'(stat_drop_cnt[3:0]), 128'd0);

    // HWM pulse between frames blocks the next frame entirely.
    fifo_above_hwm[0] = 1'b1; tick();
    fifo_above_hwm[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, (i == 3), 128'hB0 + 128'(i), 16'hFFFF); tick();
      check_val($sformatf("t2_drop_valid%0d", i), DATA_W'(o_rx_tvalid[0]), '0);
      check_val($sformatf("t2_lossf%0d", i), DATA_W'(loss_frame[0]), (i == 0) ? 128'd1 : 128'd0);
    end
    drive0(1'b0, 1'b0, 128'h0, 16'h0); tick();
    check_val("t2_cnt", DATA_W'(stat_drop_cnt[3:0]), 128'd1);
    fifo_below_lwm[0] = 1'b1; tick();
    fifo_below_lwm[0] = 1'b0;
    drive0(1'b1, 1'b0, 128'hC1, 16'hFFFF); tick();
    check_beat0("t2_fwd1", 1'b1, 1'b0, 1'b0, 128'hC1, 16'hFFFF);
    drive0(1'b1, 1'b1, 128'hC2, 16'h000F); tick();
    check_beat0("t2_fwd2", 1'b1, 1'b1, 1'b0, 128'hC2, 16'h000F);
    drive0(1'b0, 1'b0, 128'h0, 16'h0);

    // Clear, then truncate a 5-beat frame by dropping channel_up after beat 2.
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    check_val("t3_clr", DATA_W'(stat_drop_cnt[3:0]), 128'd0);
    drive0(1'b1, 1'b0, 128'hD1, 16'hFFFF); tick();
    check_beat0("t3_b1", 1'b1, 1'b0, 1'b0, 128'hD1, 16'hFFFF);
    drive0(1'b1, 1'b0, 128'hD2, 16'hFFFF); tick();
    check_beat0("t3_b2", 1'b1, 1'b0, 1'b0, 128'hD2, 16'hFFFF);
    channel_up[0] = 1'b0;
    drive0(1'b1, 1'b0, 128'hD3, 16'hFFFF); tick();
    check_beat0("t3_term", 1'b1, 1'b1, 1'b1, 128'h0, 16'h0);
    check_val("t3_lossd", DATA_W'(loss_data[0]), 128'd1);
    check_val("t3_lossf", DATA_W'(loss_frame[0]), 128'd0);
    drive0(1'b1, 1'b0, 128'hD4, 16'hFFFF); tick();
    check_val("t3_b4_valid", DATA_W'(o_rx_tvalid[0]), '0);
    check_val("t3_b4_lossd", DATA_W'(loss_data[0]), '0);
    drive0(1'b1, 1'b1, 128'hD5, 16'hFFFF); tick();
    check_val("t3_b5_valid", DATA_W'(o_rx_tvalid[0]), '0);
    check_val("t3_cnt", DATA_W'(stat_drop_cnt[3:0]), 128'd1);
    drive0(1'b0, 1'b0, 128'h0, 16'h0);
    channel_up[0] = 1'b1; tick();

    // 17 dropped single-beat frames saturate a 4-bit counter at 15.
    fifo_above_hwm[0] = 1'b1; tick();
    for (int i = 0; i < 17; i++) begin
      drive0(1'b1, 1'b1, 128'hE0, 16'hFFFF); tick();
    end
    check_val("t4_lossf", DATA_W'(loss_frame[0]), 128'd1);
    check_val("t4_sat_valid", DATA_W'(o_rx_tvalid[0]), '0);
    drive0(1'b0, 1'b0, 128'h0, 16'h0); tick();
    check_val("t4_sat", DATA_W'(stat_drop_cnt[3:0]), 128'd15);
    stat_clr = 1'b1; tick();
    check_val("t4_clr", DATA_W'(stat_drop_cnt[3:0]), 128'd0);
    drive0(1'b1, 1'b1, 128'hE1, 16'hFFFF); tick();
    stat_clr = 1'b0;
    check_val("t4_clr_inc", DATA_W'(stat_drop_cnt[3:0]), 128'd1);
    drive0(1'b0, 1'b0, 128'h0, 16'h0);

    // ch0 stays blocked while ch1 forwards a 3-beat frame.
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive0((i == 0), 1'b1, 128'hF0, 16'hFFFF);
      drive1(1'b1, (i == 2), 128'h100 + 128'(i), (i == 2) ? 16'h0003 : 16'hFFFF);
      tick();
      check_val($sformatf("t6_ch1_valid%0d", i), DATA_W'(o_rx_tvalid[1]), 128'd1);
      check_val($sformatf("t6_ch1_data%0d", i), o_rx_tdata[2*DATA_W-1:DATA_W], 128'h100 + 128'(i));
      check_val($sformatf("t6_ch1_last%0d", i), DATA_W'(o_rx_tlast[1]), (i == 2) ? 128'd1 : 128'd0);
      check_val($sformatf("t6_ch0_valid%0d", i), DATA_W'(o_rx_tvalid[0]), '0);
    end
    check_val("t6_ch1_keep", DATA_W'(o_rx_tkeep[2*KEEP_W-1:KEEP_W]), 128'h0003);
    drive0(1'b0, 1'b0, 128'h0, 16'h0);
    drive1(1'b0, 1'b0, 128'h0, 16'h0);
    tick();
    check_val("t6_cnts", DATA_W'(stat_drop_cnt), 128'h01);
    fifo_above_hwm[0] = 1'b0; fifo_below_lwm[0] = 1'b1; tick();
    fifo_below_lwm[0] = 1'b0;

    // Asynchronous reset mid-frame, then the next beat starts a new frame.
    drive0(1'b1, 1'b0, 128'h55, 16'hFFFF); tick();
    check_val("t5_pre_valid", DATA_W'(o_rx_tvalid[0]), 128'd1);
    drive0(1'b0, 1'b0, 128'h0, 16'h0);
    #3 rst = 1'b1;
    #1;
    check_val("t5_rst_valid", DATA_W'(o_rx_tvalid), '0);
    check_val("t5_rst_data", o_rx_tdata[DATA_W-1:0], '0);
    check_val("t5_rst_cnt", DATA_W'(stat_drop_cnt), '0);
    #2 rst = 1'b0;
    fifo_ready[0] = 1'b0;
    drive0(1'b1, 1'b1, 128'h66, 16'hFFFF); tick();
    check_val("t5_lossf", DATA_W'(loss_frame[0]), 128'd1);
    check_val("t5_lossd", DATA_W'(loss_data[0]), '0);
    check_val("t5_valid", DATA_W'(o_rx_tvalid[0]), '0);
    check_val("t5_cnt", DATA_W'(stat_drop_cnt[3:0]), 128'd1);
    drive0(1'b0, 1'b0, 128'h0, 16'h0);
    fifo_ready[0] = 1'b1; tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_aurora_rx_guard_mc
